// File: rtl/alu_sequencer.sv
// alu_sequencer: request-side controller for the shared combinational ALU.
//
// Accepts one operation at a time over a valid/ready request channel, decodes the
// 4-bit opcode into the ALU function code {subtract, bool1, bool0, shft, math} and
// drives registered operands into the ALU. It captures the ALU result and zero flag,
// then returns them over a valid/ready response channel.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid/req_ready         request handshake (ready only while idle)
//   req_op, req_x, req_y        opcode and operands
//   req_chain                   substitute the last captured result for req_x
//   alu_a, alu_b, alu_fn        registered ALU inputs
//   alu_r, alu_z                ALU result and zero flag
//   rsp_valid/rsp_ready         response handshake
//   rsp_result, rsp_zero        captured result and zero flag
//   rsp_err                     response belongs to an illegal opcode
//   op_count                    completed legal operations (wrapping)
module alu_sequencer #(
   parameter int unsigned N  = 32,
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [3:0]    req_op,
   input  logic [N-1:0]  req_x,
   input  logic [N-1:0]  req_y,
   input  logic          req_chain,
   output logic [N-1:0]  alu_a,
   output logic [N-1:0]  alu_b,
   output logic [4:0]    alu_fn,
   input  logic [N-1:0]  alu_r,
   input  logic          alu_z,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [N-1:0]  rsp_result,
   output logic          rsp_zero,
   output logic          rsp_err,
   output logic [CW-1:0] op_count
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    alu_a_q, alu_a_d;
   logic [N-1:0]    alu_b_q, alu_b_d;
   logic [4:0]      alu_fn_q, alu_fn_d;
   logic [N-1:0]    result_q, result_d;
   logic            zero_q, zero_d;
   logic            err_q, err_d;
   logic [N-1:0]    last_q, last_d;
   logic [CW-1:0]   count_q, count_d;

   logic [4:0]      dec_fn;
   logic            dec_legal;
   logic            dec_shift;
   logic [N-1:0]    x_sel;

   // Opcode decode
   always_comb begin
      dec_fn    = 5'b00000;
      dec_legal = 1'b1;
      dec_shift = 1'b0;
      case (req_op)
         4'd0:    dec_fn = 5'b00001;
         4'd1:    dec_fn = 5'b10001;
         4'd2:    dec_fn = 5'b00000;
         4'd3:    dec_fn = 5'b00100;
         4'd4:    dec_fn = 5'b01000;
         4'd5:    dec_fn = 5'b01100;
         4'd6:    begin dec_fn = 5'b00010; dec_shift = 1'b1; end
         4'd7:    begin dec_fn = 5'b00110; dec_shift = 1'b1; end
         4'd8:    begin dec_fn = 5'b01010; dec_shift = 1'b1; end
         4'd9:    dec_fn = 5'b10111;
         4'd10:   dec_fn = 5'b10011;
         default: dec_legal = 1'b0;
      endcase
   end

   assign x_sel = req_chain ? last_q : req_x;

   always_comb begin
      state_d  = state_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      alu_fn_d = alu_fn_q;
      result_d = result_q;
      zero_d   = zero_q;
      err_d    = err_q;
      last_d   = last_q;
      count_d  = count_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               if (dec_legal) begin
                  // The ALU takes the shift amount on A and the data on B.
                  alu_a_d  = dec_shift ? req_y : x_sel;
                  alu_b_d  = dec_shift ? x_sel : req_y;
                  alu_fn_d = dec_fn;
                  state_d  = StExec;
               end else begin
                  result_d = '0;
                  zero_d   = 1'b0;
                  err_d    = 1'b1;
                  state_d  = StResp;
               end
            end
         end
         StExec: begin
            result_d = alu_r;
            zero_d   = alu_z;
            err_d    = 1'b0;
            last_d   = alu_r;
            state_d  = StResp;
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
               if (!err_q) count_d = count_q + CW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_fn_q <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
         last_q   <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_fn_q <= alu_fn_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         err_q    <= err_d;
         last_q   <= last_d;
         count_q  <= count_d;
      end
   end

   assign req_ready  = (state_q == StIdle);
   assign rsp_valid  = (state_q == StResp);
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_fn     = alu_fn_q;
   assign rsp_result = result_q;
   assign rsp_zero   = zero_q;
   assign rsp_err    = err_q;
   assign op_count   = count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed table, reset-in-flight sequence,
// and randomized operations checked against an opcode-level reference model.
module tb_alu_sequencer;

   localparam int unsigned N  = 32;
   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_op;
   logic [N-1:0]  req_x;
   logic [N-1:0]  req_y;
   logic          req_chain;
   logic [N-1:0]  alu_a;
   logic [N-1:0]  alu_b;
   logic [4:0]    alu_fn;
   logic [N-1:0]  alu_r;
   logic          alu_z;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [N-1:0]  rsp_result;
   logic          rsp_zero;
   logic          rsp_err;
   logic [CW-1:0] op_count;

   int errors = 0;
   int checks = 0;

   alu_sequencer #(.N(N), .CW(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_chain  (req_chain),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_fn     (alu_fn),
      .alu_r      (alu_r),
      .alu_z      (alu_z),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_err    (rsp_err),
      .op_count   (op_count)
   );

   always #5 clk = ~clk;

   // Combinational ALU stand-in: shift amount on A, shift data on B.
   always_comb begin
      alu_r = '0;
      case (alu_fn)
         5'b00001: alu_r = alu_a + alu_b;
         5'b10001: alu_r = alu_a - alu_b;
         5'b00000: alu_r = alu_a & alu_b;
         5'b00100: alu_r = alu_a | alu_b;
         5'b01000: alu_r = alu_a ^ alu_b;
         5'b01100: alu_r = ~(alu_a | alu_b);
         5'b00010: alu_r = alu_b << alu_a[4:0];
         5'b00110: alu_r = alu_b >> alu_a[4:0];
         5'b01010: alu_r = $signed(alu_b) >>> alu_a[4:0];
         5'b10111: alu_r = {31'b0, $signed(alu_a) < $signed(alu_b)};
         5'b10011: alu_r = {31'b0, alu_a < alu_b};
         default:  alu_r = '0;
      endcase
      alu_z = (alu_r == '0);
   end

   // Reference model state
   logic [4:0]    fn_tab [16];
   logic [N-1:0]  m_last;
   logic [CW-1:0] m_count;
   logic [N-1:0]  m_a, m_b;
   logic [4:0]    m_fn;

   function automatic logic [N-1:0] ref_result(input logic [3:0] op, input logic [N-1:0] x,
                                               input logic [N-1:0] y);
      logic [N-1:0] r;
      int sh;
      sh = int'(y % 32);
      case (op)
         4'd0:    r = x + y;
         4'd1:    r = x - y;
         4'd2:    r = x & y;
         4'd3:    r = x | y;
         4'd4:    r = x ^ y;
         4'd5:    r = ~(x | y);
         4'd6:    r = x << sh;
         4'd7:    r = x >> sh;
         4'd8:    r = $signed(x) >>> sh;
         4'd9:    r = ($signed(x) < $signed(y)) ? 1 : 0;
         4'd10:   r = (x < y) ? 1 : 0;
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One complete transaction; called on a negedge, returns on a negedge.
   task automatic run_op(input logic [3:0] op, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic chain, input int hold, input logic [N-1:0] e_res,
                         input logic e_zero, input logic e_err);
      logic legal;
      logic [N-1:0] xe;
      int cyc;
      legal = (op <= 4'd10);
      xe = chain ? m_last : x;
      if (legal) begin
         m_fn = fn_tab[op];
         m_a  = (op >= 4'd6 && op <= 4'd8) ? y : xe;
         m_b  = (op >= 4'd6 && op <= 4'd8) ? xe : y;
      end
      chk("req_ready_idle", N'(req_ready), N'(1));
      req_valid = 1'b1; req_op = op; req_x = x; req_y = y; req_chain = chain;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_op = 4'($urandom); req_x = $urandom; req_y = $urandom; req_chain = 1'($urandom);
      cyc = 1;
      while (!rsp_valid && cyc < 10) begin
         if (cyc == 1 && legal) begin
            chk("exec_alu_fn", N'(alu_fn), N'(m_fn));
            chk("exec_alu_a", alu_a, m_a);
            chk("exec_alu_b", alu_b, m_b);
         end
         @(negedge clk);
         cyc++;
      end
      chk("latency", N'(cyc), legal ? N'(2) : N'(1));
      chk("rsp_result", rsp_result, e_res);
      chk("rsp_zero", N'(rsp_zero), N'(e_zero));
      chk("rsp_err", N'(rsp_err), N'(e_err));
      if (!legal) chk("alu_fn_unchanged", N'(alu_fn), N'(m_fn));
      if (legal) m_last = e_res;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_result", rsp_result, e_res);
         chk("hold_valid", N'(rsp_valid), N'(1));
         chk("hold_req_ready", N'(req_ready), N'(0));
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      if (!e_err) m_count = m_count + 1'b1;
      chk("rsp_valid_fall", N'(rsp_valid), N'(0));
      chk("op_count", N'(op_count), N'(m_count));
   endtask

   typedef struct {
      logic [3:0]   op;
      logic [N-1:0] x;
      logic [N-1:0] y;
      logic         chain;
      int           hold;
      logic [N-1:0] res;
      logic         zero;
      logic         err;
   } vec_t;

   vec_t tbl [15];

   initial begin
      fn_tab = '{5'b00001, 5'b10001, 5'b00000, 5'b00100, 5'b01000, 5'b01100,
                 5'b00010, 5'b00110, 5'b01010, 5'b10111, 5'b10011,
                 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
      tbl[0]  = '{4'd0,  32'd5,        32'd7,        1'b0, 0, 32'd12,       1'b0, 1'b0};
      tbl[1]  = '{4'd1,  32'd9,        32'd9,        1'b0, 0, 32'd0,        1'b1, 1'b0};
      tbl[2]  = '{4'd9,  32'hFFFFFFFF, 32'd1,        1'b0, 0, 32'd1,        1'b0, 1'b0};
      tbl[3]  = '{4'd10, 32'hFFFFFFFF, 32'd1,        1'b0, 0, 32'd0,        1'b1, 1'b0};
      tbl[4]  = '{4'd6,  32'd1,        32'd4,        1'b0, 0, 32'h10,       1'b0, 1'b0};
      tbl[5]  = '{4'd8,  32'h80000000, 32'd31,       1'b0, 0, 32'hFFFFFFFF, 1'b0, 1'b0};
      tbl[6]  = '{4'd7,  32'h80000000, 32'd31,       1'b0, 0, 32'd1,        1'b0, 1'b0};
      tbl[7]  = '{4'd0,  32'd3,        32'd4,        1'b0, 0, 32'd7,        1'b0, 1'b0};
      tbl[8]  = '{4'd0,  32'd99,       32'd10,       1'b1, 0, 32'd17,       1'b0, 1'b0};
      tbl[9]  = '{4'd12, 32'd55,       32'd66,       1'b1, 0, 32'd0,        1'b0, 1'b1};
      tbl[10] = '{4'd0,  32'd1000,     32'd1,        1'b1, 0, 32'd18,       1'b0, 1'b0};
      tbl[11] = '{4'd4,  32'hA5A5A5A5, 32'hFFFFFFFF, 1'b0, 5, 32'h5A5A5A5A, 1'b0, 1'b0};
      tbl[12] = '{4'd3,  32'd0,        32'd0,        1'b0, 0, 32'd0,        1'b1, 1'b0};
      tbl[13] = '{4'd2,  32'hF0F0,     32'hFF00,     1'b0, 1, 32'hF000,     1'b0, 1'b0};
      tbl[14] = '{4'd5,  32'd0,        32'd0,        1'b0, 0, 32'hFFFFFFFF, 1'b0, 1'b0};

      rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_x = '0; req_y = '0;
      req_chain = 1'b0; rsp_ready = 1'b0;
      m_last = '0; m_count = '0; m_a = '0; m_b = '0; m_fn = '0;
      repeat (2) @(negedge clk);
      chk("rst_alu_a", alu_a, '0);
      chk("rst_alu_b", alu_b, '0);
      chk("rst_alu_fn", N'(alu_fn), '0);
      chk("rst_rsp_valid", N'(rsp_valid), '0);
      chk("rst_rsp_result", rsp_result, '0);
      chk("rst_flags", N'({rsp_zero, rsp_err}), '0);
      chk("rst_op_count", N'(op_count), '0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", N'(req_ready), N'(1));

      for (int i = 0; i < 15; i++)
         run_op(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].chain, tbl[i].hold,
                tbl[i].res, tbl[i].zero, tbl[i].err);

      // Reset while an operation is executing.
      req_valid = 1'b1; req_op = 4'd0; req_x = 32'd20; req_y = 32'd22; req_chain = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_alu_a", alu_a, '0);
      chk("mid_rst_alu_fn", N'(alu_fn), '0);
      chk("mid_rst_rsp_valid", N'(rsp_valid), '0);
      chk("mid_rst_op_count", N'(op_count), '0);
      chk("mid_rst_rsp_result", rsp_result, '0);
      @(negedge clk);
      rst_n = 1'b1;
      m_last = '0; m_count = '0; m_a = '0; m_b = '0; m_fn = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_no_rsp", N'(rsp_valid), '0);
      end
      // Chained op after reset sees a cleared last-result register.
      run_op(4'd0, 32'd777, 32'd5, 1'b1, 0, 32'd5, 1'b0, 1'b0);

      // Randomized operations against the model.
      for (int i = 0; i < 60; i++) begin
         logic [3:0] op;
         logic [N-1:0] x, y, r;
         logic ch;
         op = 4'($urandom_range(0, 15));
         x  = $urandom;
         y  = ($urandom_range(0, 3) == 0) ? x : $urandom;
         ch = 1'($urandom);
         r  = (op <= 4'd10) ? ref_result(op, ch ? m_last : x, y) : '0;
         run_op(op, x, y, ch, $urandom_range(0, 2), r, (op <= 4'd10) && (r == '0),
                op > 4'd10);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
